// File: rtl/spi_pwm_reg_slave.sv
// SPI mode-0 slave that turns 16-bit frames into PWM duty-register writes and readback.
// sclk/cs/mosi are oversampled in the clk domain, so f_clk must be at least 4*f_sclk.
module spi_pwm_reg_slave #(
    parameter int CHANNELS    = 7,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err
);

    localparam logic [ADDR_W:0] CH_LIM = CHANNELS[ADDR_W:0];

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall;
    logic [DATA_W-2:0]      rx_sr;
    logic [DATA_W-1:0]      rx_next;
    logic [4:0]             bit_cnt, bit_cnt_inc;
    logic                   rw_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_q;
    logic [DATA_W-1:0]      tx_sr;
    logic                   tx_load;
    logic                   overrun;
    logic                   miso_q;
    logic                   addr_ok;
    logic                   commit;
    logic                   bad_frame;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign rx_next     = {rx_sr, mosi_s};
    assign bit_cnt_inc = (bit_cnt == 5'd16) ? bit_cnt : bit_cnt + 5'd1;
    assign addr_ok     = ({1'b0, addr_q} < CH_LIM);

    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_IDLE: if (cs_s) state_next = S_IDLE;
            S_IDLE:      if (!cs_s) state_next = S_CMD;
            S_CMD: begin
                if (cs_s)                                 state_next = S_IDLE;
                else if (sclk_rise && bit_cnt == 5'd7)    state_next = S_DATA;
            end
            S_DATA: begin
                if (cs_s)                                 state_next = S_IDLE;
                else if (sclk_rise && bit_cnt == 5'd15)   state_next = S_DONE;
            end
            S_DONE:      if (cs_s) state_next = S_IDLE;
            default:     state_next = S_WAIT_IDLE;
        endcase
    end

    always_comb begin
        commit    = 1'b0;
        bad_frame = 1'b0;
        miso      = 1'b0;
        case (state)
            S_CMD:  bad_frame = cs_s;
            S_DATA: begin
                bad_frame = cs_s;
                miso      = miso_q & ~cs_s;
            end
            S_DONE: begin
                commit    = cs_s & rw_q & addr_ok & ~overrun;
                bad_frame = cs_s & (~addr_ok | overrun);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tx_sr     <= '0;
            tx_load   <= 1'b0;
            overrun   <= 1'b0;
            miso_q    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            wr_en     <= commit;
            frame_err <= bad_frame;
            if (commit) begin
                wr_addr <= addr_q;
                wr_data <= data_q;
            end
            case (state)
                S_WAIT_IDLE, S_IDLE: begin
                    rx_sr   <= '0;
                    bit_cnt <= '0;
                    tx_sr   <= '0;
                    tx_load <= 1'b0;
                    overrun <= 1'b0;
                    miso_q  <= 1'b0;
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        rx_sr   <= rx_next[DATA_W-2:0];
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt == 5'd7) begin
                            rw_q    <= rx_next[DATA_W-1];
                            addr_q  <= rx_next[DATA_W-2 -: ADDR_W];
                            rd_addr <= rx_next[DATA_W-2 -: ADDR_W];
                            tx_load <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (sclk_rise) begin
                        rx_sr   <= rx_next[DATA_W-2:0];
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt == 5'd15) data_q <= rx_next;
                    end
                    // rd_data settles one clk after rd_addr, well before the first fall
                    if (tx_load) begin
                        tx_sr   <= (!rw_q && addr_ok) ? rd_data : '0;
                        tx_load <= 1'b0;
                    end else if (sclk_fall) begin
                        miso_q <= tx_sr[DATA_W-1];
                        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    if (sclk_rise) begin
                        overrun <= 1'b1;
                        bit_cnt <= bit_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
